// File: rtl/jam_pkg.sv
// Shared definitions for the jam sequencing controller and its jam operation unit.
package jam_pkg;

  // Default timing constants, in clock cycles
  localparam int DEBOUNCE_CYC_DEF = 4;
  localparam int DETECT_CYC_DEF   = 16;
  localparam int SLOT_CYC_DEF     = 32;
  localparam int CLEAR_CYC_DEF    = 8;

  localparam int NUM_SENSORS = 4;

  // State codes as seen on the jam_state status output
  localparam logic [2:0] CODE_IDLE   = 3'd0;
  localparam logic [2:0] CODE_DETECT = 3'd1;
  localparam logic [2:0] CODE_START  = 3'd2;
  localparam logic [2:0] CODE_SERVE  = 3'd3;
  localparam logic [2:0] CODE_CLEAR  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = CODE_IDLE,
    ST_DETECT = CODE_DETECT,
    ST_START  = CODE_START,
    ST_SERVE  = CODE_SERVE,
    ST_CLEAR  = CODE_CLEAR
  } jam_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jam_seq_ctrl_if.sv
// Sensor inputs, enable and jam status outputs of the jam sequencing controller.
interface jam_seq_ctrl_if;

  logic       raw_sensor_0;
  logic       raw_sensor_1;
  logic       raw_sensor_2;
  logic       raw_sensor_3;
  logic       ctrl_en;
  logic       jam_sensor_0;
  logic       jam_sensor_1;
  logic       jam_sensor_2;
  logic       jam_sensor_3;
  logic       jam_op_en;
  logic       jam_start;
  logic       jam_rotation;
  logic [2:0] jam_state;

  // Driver side: supplies raw sensors and enable, observes jam status
  modport master (
    output raw_sensor_0, raw_sensor_1, raw_sensor_2, raw_sensor_3, ctrl_en,
    input  jam_sensor_0, jam_sensor_1, jam_sensor_2, jam_sensor_3,
    input  jam_op_en, jam_start, jam_rotation, jam_state
  );

  // Controller side
  modport slave (
    input  raw_sensor_0, raw_sensor_1, raw_sensor_2, raw_sensor_3, ctrl_en,
    output jam_sensor_0, jam_sensor_1, jam_sensor_2, jam_sensor_3,
    output jam_op_en, jam_start, jam_rotation, jam_state
  );

endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a debounce filter: the filtered level
// flips only after the synchronised input has disagreed with it for
// DEBOUNCE_CYC consecutive cycles.
module sensor_debounce
  import jam_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filtered
);

  localparam int              CW       = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt_q;

  // Bring the asynchronous sensor into the clk domain
  // NOTE: non-blocking assignments make both flops sample the old values, so
  // the chain is really two stages deep regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive disagreeing cycles; flip the filtered level on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      filtered <= 1'b0;
    end else if (sync_q2 == filtered) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q    <= '0;
      filtered <= ~filtered;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/jam_seq_ctrl.sv
// Jam sequencing controller: debounces four jam sensors, qualifies a jam,
// then serves jammed roads in fixed time slots until the sensors stay clear.
module jam_seq_ctrl
  import jam_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int DETECT_CYC   = DETECT_CYC_DEF,
  parameter int SLOT_CYC     = SLOT_CYC_DEF,
  parameter int CLEAR_CYC    = CLEAR_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  jam_seq_ctrl_if.slave  bus
);

  localparam int DW = cnt_w(DETECT_CYC);
  localparam int SW = cnt_w(SLOT_CYC);
  localparam int KW = cnt_w(CLEAR_CYC);

  localparam logic [DW-1:0] DET_LAST  = DW'(DETECT_CYC - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYC - 1);
  localparam logic [KW-1:0] CLR_LAST  = KW'(CLEAR_CYC - 1);

  logic [NUM_SENSORS-1:0] raw_vec;
  logic [NUM_SENSORS-1:0] filt_vec;
  logic                   any_high;

  jam_state_e    state_q, state_d;
  logic [DW-1:0] det_q, det_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [KW-1:0] clr_q, clr_d;

  assign raw_vec = {bus.raw_sensor_3, bus.raw_sensor_2, bus.raw_sensor_1, bus.raw_sensor_0};

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_deb
    sensor_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (raw_vec[g]),
      .filtered (filt_vec[g])
    );
  end

  assign any_high = |filt_vec;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      det_q   <= '0;
      slot_q  <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      slot_q  <= slot_d;
      clr_q   <= clr_d;
    end
  end

  // Next-state and counter update; a low enable overrides every transition
  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    det_d   = det_q;
    slot_d  = slot_q;
    clr_d   = clr_q;
    if (!bus.ctrl_en) begin
      state_d = ST_IDLE;
      det_d   = '0;
      slot_d  = '0;
      clr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_high) begin
            state_d = ST_DETECT;
            det_d   = '0;
          end
        end
        ST_DETECT: begin
          if (!any_high) begin
            state_d = ST_IDLE;
            det_d   = '0;
          end else if (det_q == DET_LAST) begin
            state_d = ST_START;
            det_d   = '0;
          end else begin
            det_d = det_q + 1'b1;
          end
        end
        ST_START: begin
          state_d = ST_SERVE;
          slot_d  = '0;
        end
        ST_SERVE: begin
          // The rotation pulse is decoded from slot_q, so it is still issued
          // when the sensors clear on the terminal count.
          slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
          if (!any_high) begin
            state_d = ST_CLEAR;
            slot_d  = '0;
            clr_d   = '0;
          end
        end
        ST_CLEAR: begin
          if (any_high) begin
            state_d = ST_SERVE;
            slot_d  = '0;
            clr_d   = '0;
          end else if (clr_q == CLR_LAST) begin
            state_d = ST_IDLE;
            clr_d   = '0;
          end else begin
            clr_d = clr_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          det_d   = '0;
          slot_d  = '0;
          clr_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from registers only, so reset clears them immediately
  assign bus.jam_sensor_0 = filt_vec[0];
  assign bus.jam_sensor_1 = filt_vec[1];
  assign bus.jam_sensor_2 = filt_vec[2];
  assign bus.jam_sensor_3 = filt_vec[3];
  assign bus.jam_op_en    = (state_q == ST_START) || (state_q == ST_SERVE) || (state_q == ST_CLEAR);
  assign bus.jam_start    = (state_q == ST_START);
  assign bus.jam_rotation = (state_q == ST_SERVE) && (slot_q == SLOT_LAST);
  assign bus.jam_state    = state_q;

endmodule

// File: tb/tb_jam_seq_ctrl.sv
// Self-checking bench for jam_seq_ctrl: directed timing scenarios followed by
// random sensor traffic, all compared against a cycle model of the rules.
module tb_jam_seq_ctrl;
  import jam_pkg::*;

  localparam int DEB  = 4;
  localparam int DET  = 16;
  localparam int SLOT = 32;
  localparam int CLR  = 8;

  localparam int M_IDLE = 0, M_DETECT = 1, M_START = 2, M_SERVE = 3, M_CLEAR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  jam_seq_ctrl_if bus ();

  jam_seq_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .DETECT_CYC   (DET),
    .SLOT_CYC     (SLOT),
    .CLEAR_CYC    (CLR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] cur_raw;
  logic       cur_en;

  // Reference model: sensor pipeline plus the sequencing phase
  bit m_s1   [4];
  bit m_s2   [4];
  bit m_filt [4];
  int m_run  [4];   // consecutive cycles the synced level disagreed with the filter
  int m_phase;
  int m_t;          // cycles spent in DETECT or CLEAR
  int m_slot;       // cycles since the current serving slot began, mod SLOT

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] r, input logic e);
    cur_raw          = r;
    cur_en           = e;
    bus.raw_sensor_0 = r[0];
    bus.raw_sensor_1 = r[1];
    bus.raw_sensor_2 = r[2];
    bus.raw_sensor_3 = r[3];
    bus.ctrl_en      = e;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_filt[i] = 0; m_run[i] = 0;
    end
    m_phase = M_IDLE;
    m_t     = 0;
    m_slot  = 0;
  endtask

  // Advance the model by one clock using the inputs held during that cycle
  task automatic model_edge();
    bit any;
    any = m_filt[0] | m_filt[1] | m_filt[2] | m_filt[3];
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_filt[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DEB) begin
          m_filt[i] = !m_filt[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = cur_raw[i];
    end
    if (!cur_en) begin
      m_phase = M_IDLE; m_t = 0; m_slot = 0;
    end else if (m_phase == M_IDLE) begin
      if (any) begin m_phase = M_DETECT; m_t = 0; end
    end else if (m_phase == M_DETECT) begin
      if (!any)              m_phase = M_IDLE;
      else if (m_t == DET-1) m_phase = M_START;
      else                   m_t = m_t + 1;
    end else if (m_phase == M_START) begin
      m_phase = M_SERVE; m_slot = 0;
    end else if (m_phase == M_SERVE) begin
      m_slot = (m_slot + 1) % SLOT;
      if (!any) begin m_phase = M_CLEAR; m_t = 0; end
    end else begin
      if (any)               begin m_phase = M_SERVE; m_slot = 0; end
      else if (m_t == CLR-1) m_phase = M_IDLE;
      else                   m_t = m_t + 1;
    end
  endtask

  task automatic compare_model(input string tag);
    logic [3:0] dut_sens, exp_sens;
    dut_sens = {bus.jam_sensor_3, bus.jam_sensor_2, bus.jam_sensor_1, bus.jam_sensor_0};
    exp_sens = {m_filt[3], m_filt[2], m_filt[1], m_filt[0]};
    check({tag, "/sens"},  8'(dut_sens), 8'(exp_sens));
    check({tag, "/state"}, 8'(bus.jam_state), 8'(m_phase));
    check({tag, "/op_en"}, 8'(bus.jam_op_en),
          8'(m_phase == M_START || m_phase == M_SERVE || m_phase == M_CLEAR));
    check({tag, "/start"}, 8'(bus.jam_start), 8'(m_phase == M_START));
    check({tag, "/rot"},   8'(bus.jam_rotation), 8'(m_phase == M_SERVE && m_slot == SLOT-1));
  endtask

  // One clock: model and DUT advance together, outputs sampled 1 after the edge
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/sens"},  8'({bus.jam_sensor_3, bus.jam_sensor_2, bus.jam_sensor_1, bus.jam_sensor_0}), 8'h0);
    check({tag, "/state"}, 8'(bus.jam_state), 8'h0);
    check({tag, "/op_en"}, 8'(bus.jam_op_en), 8'h0);
    check({tag, "/start"}, 8'(bus.jam_start), 8'h0);
    check({tag, "/rot"},   8'(bus.jam_rotation), 8'h0);
  endtask

  // Leaves the bench aligned 1 after a rising edge with reset released
  task automatic finish_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // From idle with all sensors low: hold sensor 2 until SERVE with slot 0
  task automatic enter_serve(input string tag);
    set_in(4'b0100, 1'b1);
    repeat (24) step(tag);
    check({tag, "/in_serve"}, 8'(bus.jam_state), 8'd3);
  endtask

  task automatic settle(input string tag);
    set_in(4'b0000, 1'b1);
    repeat (24) step(tag);
    check({tag, "/idle"}, 8'(bus.jam_state), 8'd0);
  endtask

  initial begin
    logic [3:0] r;
    logic       e;

    // Reset state
    set_in(4'b0000, 1'b1);
    rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    finish_reset();

    // Short 3-cycle glitch never passes the debouncer
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) set_in(4'b0001, 1'b1);
      if (k == 4) set_in(4'b0000, 1'b1);
      step("glitch");
      check("glitch_sens0", 8'(bus.jam_sensor_0), 8'd0);
      check("glitch_state", 8'(bus.jam_state), 8'd0);
    end

    // Sensor drops after 10 DETECT cycles: back to IDLE without a jam
    for (int k = 1; k <= 25; k++) begin
      if (k == 1)  set_in(4'b0001, 1'b1);
      if (k == 12) set_in(4'b0000, 1'b1);
      step("abort");
      check("abort_start", 8'(bus.jam_start), 8'd0);
      check("abort_op_en", 8'(bus.jam_op_en), 8'd0);
      if (k == 7)  check("abort_detect_entry", 8'(bus.jam_state), 8'd1);
      if (k == 16) check("abort_detect_last", 8'(bus.jam_state), 8'd1);
      if (k == 18) check("abort_idle", 8'(bus.jam_state), 8'd0);
    end
    settle("abort_settle");

    // Held sensor 2: cycle 0 is the first synced-high cycle (after two edges)
    set_in(4'b0100, 1'b1);
    step("hold_sync");
    step("hold_sync");
    for (int k = 0; k <= 90; k++) begin
      if (k > 0) step("hold");
      check("hold_sens2", 8'(bus.jam_sensor_2), 8'(k >= 4));
      check("hold_start", 8'(bus.jam_start), 8'(k == 21));
      check("hold_rot",   8'(bus.jam_rotation), 8'(k == 53 || k == 85));
      check("hold_op_en", 8'(bus.jam_op_en), 8'(k >= 21));
      if (k == 4) check("hold_idle_c4", 8'(bus.jam_state), 8'd0);
      if (k == 5) check("hold_detect_c5", 8'(bus.jam_state), 8'd1);
    end

    // Enable low mid-SERVE: IDLE next cycle, debouncers keep running
    set_in(4'b0100, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step("en_low");
      check("en_low_state", 8'(bus.jam_state), 8'd0);
      check("en_low_op_en", 8'(bus.jam_op_en), 8'd0);
      check("en_low_start", 8'(bus.jam_start), 8'd0);
      check("en_low_rot",   8'(bus.jam_rotation), 8'd0);
      check("en_low_sens2", 8'(bus.jam_sensor_2), 8'd1);
    end
    settle("en_low_settle");

    // Short clear in SERVE returns to SERVE with a fresh slot
    enter_serve("reclr_enter");
    for (int k = 1; k <= 50; k++) begin
      if (k == 1) set_in(4'b0000, 1'b1);
      if (k == 6) set_in(4'b0100, 1'b1);
      step("reclr");
      check("reclr_start", 8'(bus.jam_start), 8'd0);
      check("reclr_rot",   8'(bus.jam_rotation), 8'(k == 43));
      if (k >= 7 && k <= 11) check("reclr_in_clear", 8'(bus.jam_state), 8'd4);
      if (k == 12) check("reclr_back_serve", 8'(bus.jam_state), 8'd3);
    end
    // Clear held for the full clear window: exit to IDLE
    for (int k = 1; k <= 16; k++) begin
      if (k == 1) set_in(4'b0000, 1'b1);
      step("exit");
      check("exit_op_en", 8'(bus.jam_op_en), 8'(k <= 14));
      check("exit_rot",   8'(bus.jam_rotation), 8'd0);
      if (k >= 7 && k <= 14) check("exit_in_clear", 8'(bus.jam_state), 8'd4);
      if (k == 15) check("exit_idle", 8'(bus.jam_state), 8'd0);
    end
    settle("exit_settle");

    // Clear coinciding with the slot terminal count still rotates
    enter_serve("tc_enter");
    for (int k = 1; k <= 33; k++) begin
      if (k == 26) set_in(4'b0000, 1'b1);
      step("tc");
      check("tc_rot", 8'(bus.jam_rotation), 8'(k == 31));
      if (k == 31) check("tc_serve", 8'(bus.jam_state), 8'd3);
      if (k == 32) check("tc_clear", 8'(bus.jam_state), 8'd4);
    end
    settle("tc_settle");

    // Asynchronous reset mid-SERVE, then full requalification
    enter_serve("arst_enter");
    repeat (3) step("arst_serve");
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    finish_reset();
    for (int k = 1; k <= 24; k++) begin
      step("requal");
      check("requal_start", 8'(bus.jam_start), 8'(k == 23));
      check("requal_op_en", 8'(bus.jam_op_en), 8'(k >= 23));
    end
    settle("requal_settle");

    // Random sensor traffic with occasional enable drops
    r = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) r[$urandom_range(0, 3)] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0) r = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 149) != 0);
      set_in(r, e);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
